// File: rtl/filter_pkg.sv
// Shared constants and types for the averaging noise filter control block.
package filter_pkg;

  // Sample width, window length and its log2 (address width / scaling shift).
  localparam int DATA_W     = 24;
  localparam int DEPTH      = 8;
  localparam int LOG2_DEPTH = 3;

  // Accumulator carries LOG2_DEPTH guard bits above the sample width.
  localparam int ACC_W = DATA_W + LOG2_DEPTH;

  // Index of the last slot in the window; reaching it while filling
  // completes the window.
  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = LOG2_DEPTH'(DEPTH - 1);

  typedef enum logic {
    FILL   = 1'b0,
    STEADY = 1'b1
  } state_t;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Widen a sample to accumulator width, preserving sign.
  function automatic acc_t sext_acc(input sample_t s);
    return {{LOG2_DEPTH{s[DATA_W-1]}}, s};
  endfunction

endpackage

// File: rtl/filter_ctrl.sv
// Control and accumulate half of the moving-average noise filter.
// Drives the sample buffer (addresses, strobes, full flag, pre-scaled data),
// keeps a running sum of the last DEPTH scaled samples and presents one
// average per accepted input through a single-entry output register.
module filter_ctrl
  import filter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  buf_read,
  output logic                  buf_write,
  output logic                  buf_full,
  output logic [LOG2_DEPTH-1:0] buf_read_addr,
  output logic [LOG2_DEPTH-1:0] buf_write_addr,
  output logic [DATA_W-1:0]     buf_writedata,
  input  logic [DATA_W-1:0]     buf_out
);

  state_t                state_reg, state_next;
  logic [LOG2_DEPTH-1:0] count_reg, count_next;
  logic [LOG2_DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
  acc_t                  acc_reg, acc_next;
  logic                  out_valid_reg, out_valid_next;
  sample_t               out_data_reg, out_data_next;

  sample_t scaled;
  sample_t oldest;
  logic    accept;

  // Each stored sample is pre-divided by DEPTH so the window sum is the mean.
  assign scaled = sample_t'($signed(in_data) >>> LOG2_DEPTH);
  assign oldest = sample_t'(buf_out);

  // The output register can take a new average when empty or being drained;
  // held low in reset so nothing is considered accepted then.
  assign in_ready = reset_n & (~out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  // The oldest entry lives in the slot about to be overwritten.
  assign buf_write_addr = wr_ptr_reg;
  assign buf_read_addr  = wr_ptr_reg;
  assign buf_writedata  = scaled;
  assign buf_full       = (state_reg == STEADY);
  assign buf_write      = accept;
  assign buf_read       = accept & (state_reg == STEADY);

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Next-state, window bookkeeping and accumulator update.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    wr_ptr_next    = wr_ptr_reg;
    acc_next       = acc_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;

    if (accept) begin
      wr_ptr_next = wr_ptr_reg + LOG2_DEPTH'(1);
      unique case (state_reg)
        FILL: begin
          // Missing samples count as zero, so the output ramps up.
          acc_next   = acc_reg + sext_acc(scaled);
          count_next = count_reg + LOG2_DEPTH'(1);
          if (count_reg == LAST_IDX) begin
            state_next = STEADY;
          end
        end
        STEADY: begin
          // buf_out is the pre-write value of the slot being replaced.
          acc_next = acc_reg + sext_acc(scaled) - sext_acc(oldest);
        end
        default: begin
          state_next = FILL;
        end
      endcase
      out_valid_next = 1'b1;
      // A full window of scaled samples always fits DATA_W.
      out_data_next  = acc_next[DATA_W-1:0];
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State register; reset discards the window and any pending output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      acc_reg       <= acc_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

endmodule
